// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream packer.
package stream_pkg;

  // Output register occupancy
  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } packer_state_e;

  // Lane counter width; at least one bit even for small ratios
  function automatic int unsigned lane_cnt_width(input int unsigned ratio);
    int unsigned w;
    w = $clog2(ratio);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/stream_packer.sv
// Width upsizer: packs RATIO narrow beats into one registered wide word, first beat in lane 0.
// Optional macro STREAM_PACKER_LAST_EN adds data_last_i / data_last_o / data_keep_o so that a
// beat flagged last closes a partial word early.
module stream_packer
  import stream_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned RATIO     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_clk_i,
  input  logic [DATA_SIZE-1:0]       data_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
`ifdef STREAM_PACKER_LAST_EN
  input  logic                       data_last_i,
  output logic                       data_last_o,
  output logic [RATIO-1:0]           data_keep_o,
`endif
  output logic [DATA_SIZE*RATIO-1:0] data_o,
  output logic                       data_valid_o,
  input  logic                       data_ready_i
);

  localparam int unsigned     CntW     = lane_cnt_width(RATIO);
  localparam int unsigned     WordW    = DATA_SIZE * RATIO;
  localparam logic [CntW-1:0] LastLane = CntW'(RATIO - 1);

  logic [CntW-1:0]  lane_cnt_q, lane_cnt_d;
  logic [WordW-1:0] acc_q, acc_d;
  packer_state_e    state_q, state_d;

  logic             w_last_beat;
  logic             w_accept;
  logic             w_complete;
  logic [WordW-1:0] w_word;
  logic [RATIO-1:0] w_keep;

`ifdef STREAM_PACKER_LAST_EN
  logic             last_q;
  logic [RATIO-1:0] keep_q;

  assign w_last_beat = (lane_cnt_q == LastLane) || data_last_i;
  assign data_last_o = last_q;
  assign data_keep_o = keep_q;
`else
  assign w_last_beat = (lane_cnt_q == LastLane);
`endif

  // Only a completing beat can be blocked, and only while the held word is not draining
  assign data_ready_o = !rst_clk_i &&
                        !(w_last_beat && (state_q == StFull) && !data_ready_i);
  assign w_accept     = data_valid_i && data_ready_o;
  assign w_complete   = w_accept && w_last_beat;
  assign data_valid_o = (state_q == StFull);

  // Assemble the outgoing word: stored lanes below the counter, the live beat at the counter,
  // zeros above (only reachable on an early last).
  always_comb begin
    w_word = '0;
    w_keep = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (k < 32'(lane_cnt_q)) begin
        w_word[k*DATA_SIZE +: DATA_SIZE] = acc_q[k*DATA_SIZE +: DATA_SIZE];
        w_keep[k]                        = 1'b1;
      end else if (k == 32'(lane_cnt_q)) begin
        w_word[k*DATA_SIZE +: DATA_SIZE] = data_i;
        w_keep[k]                        = 1'b1;
      end
    end
  end

  // Accumulator and lane counter next state
  always_comb begin
    acc_d      = acc_q;
    lane_cnt_d = lane_cnt_q;
    if (w_accept) begin
      acc_d[lane_cnt_q*DATA_SIZE +: DATA_SIZE] = data_i;
      lane_cnt_d = w_complete ? '0 : lane_cnt_q + 1'b1;
    end
  end

  // Output FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (w_complete) state_d = StFull;
      StFull:  if (data_ready_i && !w_complete) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Output FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) state_q <= StEmpty;
    else           state_q <= state_d;
  end

  // Accumulator, counter and output word registers
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      lane_cnt_q <= '0;
      acc_q      <= '0;
      data_o     <= '0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      acc_q      <= acc_d;
      if (w_complete) data_o <= w_word;
    end
  end

`ifdef STREAM_PACKER_LAST_EN
  // Sideband registers travel with the output word
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      keep_q <= '0;
      last_q <= 1'b0;
    end else if (w_complete) begin
      keep_q <= w_keep;
      last_q <= data_last_i;
    end
  end
`else
  logic w_unused_keep;
  assign w_unused_keep = ^w_keep;
`endif

endmodule
